// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter in front of a fifo, with bounded burst ownership; zero latency (combinational issue).
// Backpressure: fifo_full blocks the write and ack and freezes owner, lock and burst count.
module fifo_wr_arbiter #(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 4,
    localparam int IW        = $clog2(NREQ),
    localparam int BW        = $clog2(MAX_BURST + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*DATA_WIDTH-1:0] req_data,
    input  logic                       fifo_full,
    output logic                       fifo_write,
    output logic [DATA_WIDTH-1:0]      fifo_data_in,
    output logic [NREQ-1:0]            ack,
    output logic [IW-1:0]              grant_id,
    output logic                       busy
);

    logic [IW-1:0] owner;
    logic [IW-1:0] gid_q;
    logic [IW-1:0] cand;
    logic [IW-1:0] idx;
    logic          locked;
    logic          keep;
    logic          cand_vld;
    logic [BW-1:0] burst_cnt;

    // Scan starts one past the owner so the owner is considered last.
    always_comb begin
        keep     = locked && req[owner] && (burst_cnt < BW'(MAX_BURST));
        cand_vld = keep;
        cand     = owner;
        idx      = owner;
        if (!keep) begin
            for (int i = 1; i <= NREQ; i++) begin
                idx = IW'((int'(owner) + i) % NREQ);
                if (!cand_vld && req[idx]) begin
                    cand_vld = 1'b1;
                    cand     = idx;
                end
            end
        end
    end

    assign fifo_write = cand_vld && !fifo_full && !rst;
    assign grant_id   = rst ? '0 : (cand_vld ? cand : gid_q);
    assign busy       = |req;

    always_comb begin
        fifo_data_in = '0;
        ack          = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (cand_vld && cand == IW'(i)) begin
                fifo_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                ack[i]       = fifo_write;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner     <= IW'(NREQ - 1);
            locked    <= 1'b0;
            burst_cnt <= '0;
            gid_q     <= '0;
        end else begin
            if (cand_vld)
                gid_q <= cand;
            if (fifo_write) begin
                // An owner re-won by the scan after hitting the limit starts a fresh burst.
                if (keep) begin
                    burst_cnt <= burst_cnt + BW'(1);
                end else begin
                    owner     <= cand;
                    locked    <= 1'b1;
                    burst_cnt <= BW'(1);
                end
            end else if (!fifo_full && !req[owner]) begin
                locked    <= 1'b0;
                burst_cnt <= '0;
            end
        end
    end

endmodule
